// File: rtl/pair_pkg.sv
// Shared encodings and widths for the set/clear pair storage stage.
package pair_pkg;

   localparam logic [1:0] PAIR_HOLD = 2'b00;
   localparam logic [1:0] PAIR_SET  = 2'b10;
   localparam logic [1:0] PAIR_CLR  = 2'b01;
   localparam logic [1:0] PAIR_BAD  = 2'b11;

   localparam int unsigned LOAD_CNT_W = 8;

   typedef enum logic [0:0] {EMPTY, FULL} state_t;

endpackage

// File: rtl/pair_cell.sv
// One stored bit driven by a set/clear pair; reports conflict (11) and any
// nonzero pair to the top level.
module pair_cell
   import pair_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] pair,
   output logic       q,
   output logic       conflict,
   output logic       nonzero
);

   logic q_d;

   always_comb begin
      q_d = q;
      case (pair)
         PAIR_SET: q_d = 1'b1;
         PAIR_CLR: q_d = 1'b0;
         default:  q_d = q;   // hold and bad pair both keep the bit
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) q <= 1'b0;
      else     q <= q_d;
   end

   assign conflict = (pair == PAIR_BAD);
   assign nonzero  = (pair != PAIR_HOLD);

endmodule

// File: rtl/pair_register.sv
// Registered word fed by a set/clear pair bus, offered through valid/ready,
// with sticky conflict/overrun flags and a wrapping load counter.
module pair_register
   import pair_pkg::*;
#(
   parameter int unsigned N_BITS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:2*N_BITS] pairs,
   output logic [1:N_BITS]   q,
   output logic              q_valid,
   input  logic              q_ready,
   input  logic              clear_err,
   output logic              err_conflict,
   output logic              err_overrun,
   output logic [7:0]        load_count
);

   logic [1:N_BITS] conflict;
   logic [1:N_BITS] nonzero;

   for (genvar i = 1; i <= int'(N_BITS); i++) begin : g_cell
      pair_cell u_cell (
         .clk      (clk),
         .rst      (rst),
         .pair     ({pairs[2*i-1], pairs[2*i]}),
         .q        (q[i]),
         .conflict (conflict[i]),
         .nonzero  (nonzero[i])
      );
   end

   logic load;
   logic any_conflict;
   logic overrun;

   assign load         = |nonzero;
   assign any_conflict = |conflict;

   state_t state_q, state_d;

   logic                  conflict_q, conflict_d;
   logic                  overrun_q, overrun_d;
   logic [LOAD_CNT_W-1:0] count_q, count_d;

   always_comb begin
      state_d = state_q;
      overrun = 1'b0;
      unique case (state_q)
         EMPTY: begin
            if (load) state_d = FULL;
         end
         FULL: begin
            if (load)         overrun = !q_ready;
            else if (q_ready) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase
   end

   // Set wins over clear so an error in the clearing cycle is not lost.
   always_comb begin
      conflict_d = any_conflict | (conflict_q & ~clear_err);
      overrun_d  = overrun      | (overrun_q  & ~clear_err);
      count_d    = count_q + LOAD_CNT_W'(load);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= EMPTY;
         conflict_q <= 1'b0;
         overrun_q  <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         conflict_q <= conflict_d;
         overrun_q  <= overrun_d;
         count_q    <= count_d;
      end
   end

   assign q_valid      = (state_q == FULL);
   assign err_conflict = conflict_q;
   assign err_overrun  = overrun_q;
   assign load_count   = count_q;

endmodule

// File: tb/tb_pair_register.sv
// Scoreboard bench: each driven cycle pushes the model's expected outputs,
// which are popped and compared one edge later.
module tb_pair_register;

   localparam int N = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:2*N]  pairs;
   logic [1:N]    q;
   logic          q_valid;
   logic          q_ready;
   logic          clear_err;
   logic          err_conflict;
   logic          err_overrun;
   logic [7:0]    load_count;

   pair_register #(.N_BITS(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .pairs        (pairs),
      .q            (q),
      .q_valid      (q_valid),
      .q_ready      (q_ready),
      .clear_err    (clear_err),
      .err_conflict (err_conflict),
      .err_overrun  (err_overrun),
      .load_count   (load_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:N] q;
      logic       valid;
      logic       conflict;
      logic       overrun;
      logic [7:0] cnt;
   } exp_t;

   exp_t sb[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:N] m_q        = '0;
   logic       m_valid    = 1'b0;
   logic       m_conflict = 1'b0;
   logic       m_overrun  = 1'b0;
   logic [7:0] m_cnt      = '0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:2*N] word_pairs(input logic [1:N] w);
      logic [1:2*N] p;
      for (int i = 1; i <= N; i++) begin
         p[2*i-1] = w[i];
         p[2*i]   = ~w[i];
      end
      return p;
   endfunction

   function automatic logic [1:2*N] one_pair(input int idx, input logic [1:0] code);
      logic [1:2*N] p = '0;
      p[2*idx-1] = code[1];
      p[2*idx]   = code[0];
      return p;
   endfunction

   // Drive one cycle, predict the result, compare after the edge.
   task automatic step(input logic [1:2*N] p, input logic rdy, input logic clr, input logic r);
      exp_t e;
      logic ld, cf;
      pairs = p; q_ready = rdy; clear_err = clr; rst = r;
      ld = 1'b0; cf = 1'b0;
      if (r) begin
         m_q = '0; m_valid = 1'b0; m_conflict = 1'b0; m_overrun = 1'b0; m_cnt = '0;
      end else begin
         for (int i = 1; i <= N; i++) begin
            logic [1:0] pr;
            pr = {p[2*i-1], p[2*i]};
            if (pr != 2'b00) ld = 1'b1;
            if (pr == 2'b11) cf = 1'b1;
            if (pr == 2'b10) m_q[i] = 1'b1;
            if (pr == 2'b01) m_q[i] = 1'b0;
         end
         m_overrun  = (m_valid & ld & ~rdy) | (m_overrun & ~clr);
         m_conflict = cf | (m_conflict & ~clr);
         if (ld)                m_valid = 1'b1;
         else if (m_valid & rdy) m_valid = 1'b0;
         if (ld) m_cnt = m_cnt + 8'd1;
      end
      e = '{q: m_q, valid: m_valid, conflict: m_conflict, overrun: m_overrun, cnt: m_cnt};
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_eq("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         check_eq("q",            {16'h0, q},         {16'h0, e.q});
         check_eq("q_valid",      {31'h0, q_valid},   {31'h0, e.valid});
         check_eq("err_conflict", {31'h0, err_conflict}, {31'h0, e.conflict});
         check_eq("err_overrun",  {31'h0, err_overrun},  {31'h0, e.overrun});
         check_eq("load_count",   {24'h0, load_count},   {24'h0, e.cnt});
      end
   endtask

   initial begin
      rst = 1'b1; pairs = '0; q_ready = 1'b0; clear_err = 1'b0;
      @(posedge clk);
      #1;

      // Reset then idle
      step('0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) step('0, 1'b0, 1'b0, 1'b0);
      check_eq("idle_q", {16'h0, q}, 32'h0);
      check_eq("idle_valid", {31'h0, q_valid}, 32'h0);
      check_eq("idle_cnt", {24'h0, load_count}, 32'h0);

      // Load and consume
      step(word_pairs(16'hA5C3), 1'b0, 1'b0, 1'b0);
      check_eq("load_q", {16'h0, q}, 32'hA5C3);
      check_eq("load_valid", {31'h0, q_valid}, 32'h1);
      check_eq("load_cnt", {24'h0, load_count}, 32'h1);
      step('0, 1'b1, 1'b0, 1'b0);
      check_eq("consumed_valid", {31'h0, q_valid}, 32'h0);
      check_eq("consumed_q", {16'h0, q}, 32'hA5C3);
      step('0, 1'b1, 1'b0, 1'b0);  // ready while empty ignored

      // Overwrite while unconsumed
      step(word_pairs(16'h00FF), 1'b0, 1'b0, 1'b0);
      step(one_pair(1, 2'b10), 1'b0, 1'b0, 1'b0);
      check_eq("overrun_q", {16'h0, q}, 32'h80FF);
      check_eq("overrun_flag", {31'h0, err_overrun}, 32'h1);
      check_eq("overrun_valid", {31'h0, q_valid}, 32'h1);

      // Same, but consumer ready on the second load
      step('0, 1'b0, 1'b0, 1'b1);
      step(word_pairs(16'h00FF), 1'b0, 1'b0, 1'b0);
      step(one_pair(1, 2'b10), 1'b1, 1'b0, 1'b0);
      check_eq("no_overrun_q", {16'h0, q}, 32'h80FF);
      check_eq("no_overrun_flag", {31'h0, err_overrun}, 32'h0);
      check_eq("no_overrun_valid", {31'h0, q_valid}, 32'h1);

      // Conflict and clear behaviour
      step('0, 1'b0, 1'b0, 1'b1);
      step(one_pair(3, 2'b11) | one_pair(4, 2'b10), 1'b0, 1'b0, 1'b0);
      check_eq("conflict_q", {16'h0, q}, 32'h1000);
      check_eq("conflict_flag", {31'h0, err_conflict}, 32'h1);
      step('0, 1'b1, 1'b1, 1'b0);
      check_eq("conflict_cleared", {31'h0, err_conflict}, 32'h0);
      step(one_pair(7, 2'b11), 1'b1, 1'b1, 1'b0);
      check_eq("set_beats_clear", {31'h0, err_conflict}, 32'h1);

      // 256 load events wrap the counter
      step('0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 256; i++)
         step(one_pair(int'($urandom_range(1, N)), ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0);
      check_eq("count_wrap", {24'h0, load_count}, 32'h0);

      // Reset dominates a coincident load
      step(word_pairs(16'hFFFF) | one_pair(2, 2'b11), 1'b0, 1'b0, 1'b1);
      check_eq("rst_q", {16'h0, q}, 32'h0);
      check_eq("rst_valid", {31'h0, q_valid}, 32'h0);
      check_eq("rst_flags", {30'h0, err_conflict, err_overrun}, 32'h0);
      check_eq("rst_cnt", {24'h0, load_count}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
